// File: rtl/trap_pkg.sv
// Shared definitions for the trap entry / return sequencer: FSM states,
// machine-mode CSR addresses and the CSR op code used for writes.
package trap_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_EPC   = 3'd1,
        S_W_CAUSE = 3'd2,
        S_W_TVAL  = 3'd3,
        S_R_TVEC  = 3'd4,
        S_R_EPC   = 3'd5,
        S_REDIR   = 3'd6
    } state_e;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    localparam logic [2:0] FUNCT3_CSRRW = 3'b001;

endpackage

// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer: saves mepc/mcause/mtval, reads mtvec or mepc,
// then issues a single-cycle fetch redirect.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        trap_valid,
    input  logic        trap_is_irq,
    input  logic [4:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    output logic        trap_ready,
    output logic        stall,
    output logic [11:0] csr_addr,
    output logic        csr_we,
    output logic        csr_re,
    output logic [2:0]  funct3,
    output logic [31:0] o_data,
    input  logic [31:0] i_data,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic [2:0]  dbg_state
);

    state_e      state_q, state_d;
    logic        up_q, up_d;
    logic        irq_q, irq_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] base;

    // Handshake: a request is taken on the rising edge where trap_ready and
    // trap_valid (or mret_valid) are both high; the pipeline holds requests
    // while trap_ready is low, so nothing is queued here.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            up_q    <= 1'b0;
            irq_q   <= 1'b0;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            irq_q   <= irq_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        up_d        = 1'b1;
        irq_d       = irq_q;
        cause_d     = cause_q;
        pc_d        = pc_q;
        tval_d      = tval_q;
        tgt_d       = tgt_q;
        csr_addr    = '0;
        csr_we      = 1'b0;
        csr_re      = 1'b0;
        funct3      = '0;
        o_data      = '0;
        pc_redirect = 1'b0;
        base        = {i_data[31:2], 2'b00};
        // up_q keeps trap_ready low until the first edge after reset release.
        trap_ready  = (state_q == S_IDLE) && up_q;
        stall       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (up_q && trap_valid) begin
                    irq_d   = trap_is_irq;
                    cause_d = trap_cause;
                    pc_d    = {trap_pc[31:2], 2'b00};
                    tval_d  = trap_tval;
                    state_d = S_W_EPC;
                end else if (up_q && mret_valid) begin
                    state_d = S_R_EPC;
                end
            end
            S_W_EPC: begin
                csr_we   = 1'b1;
                funct3   = FUNCT3_CSRRW;
                csr_addr = CSR_MEPC;
                o_data   = pc_q;
                state_d  = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                csr_we   = 1'b1;
                funct3   = FUNCT3_CSRRW;
                csr_addr = CSR_MCAUSE;
                o_data   = {irq_q, 26'b0, cause_q};
                state_d  = S_W_TVAL;
            end
            S_W_TVAL: begin
                csr_we   = 1'b1;
                funct3   = FUNCT3_CSRRW;
                csr_addr = CSR_MTVAL;
                o_data   = tval_q;
                state_d  = S_R_TVEC;
            end
            S_R_TVEC: begin
                csr_re   = 1'b1;
                csr_addr = CSR_MTVEC;
                // Vectored mode only applies to interrupts; exceptions use the base.
                if (VECTORED_EN && (i_data[1:0] == 2'b01) && irq_q)
                    tgt_d = base + {25'b0, cause_q, 2'b00};
                else
                    tgt_d = base;
                state_d  = S_REDIR;
            end
            S_R_EPC: begin
                csr_re   = 1'b1;
                csr_addr = CSR_MEPC;
                tgt_d    = base;
                state_d  = S_REDIR;
            end
            S_REDIR: begin
                pc_redirect = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pc_target = tgt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: table of trap vectors run through full
// sequences, plus hand-written mret, collision and reset-abort cases.
module tb_trap_ctrl;

    typedef struct {
        logic        irq;
        logic [4:0]  cause;
        logic [31:0] pc;
        logic [31:0] tval;
        logic [31:0] mtvec;
        logic [31:0] exp_epc;
        logic [31:0] exp_cause;
        logic [31:0] exp_tgt_v;
        logic [31:0] exp_tgt_d;
    } vec_t;

    localparam logic [51:0] M_FULL = '1;
    localparam logic [51:0] M_RD   = {5'b11111, 3'b000, 12'hFFF, 32'h0};

    logic        i_clk, i_rst;
    logic        trap_valid, trap_is_irq, mret_valid;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc, trap_tval;
    logic        trap_ready, stall, csr_we, csr_re, pc_redirect;
    logic [11:0] csr_addr;
    logic [2:0]  funct3, dbg_state;
    logic [31:0] o_data, i_data, pc_target;

    logic        trap_ready_0, stall_0, csr_we_0, csr_re_0, pc_redirect_0;
    logic [11:0] csr_addr_0;
    logic [2:0]  funct3_0, dbg_state_0;
    logic [31:0] o_data_0, i_data_0, pc_target_0;

    logic [31:0] mtvec_v, mepc_v;
    int          total, bad;
    vec_t        vecs[5];

    trap_ctrl #(.VECTORED_EN(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .trap_valid(trap_valid), .trap_is_irq(trap_is_irq),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_valid(mret_valid), .trap_ready(trap_ready), .stall(stall),
        .csr_addr(csr_addr), .csr_we(csr_we), .csr_re(csr_re), .funct3(funct3),
        .o_data(o_data), .i_data(i_data), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .dbg_state(dbg_state)
    );

    trap_ctrl #(.VECTORED_EN(1'b0)) dut_direct (
        .i_clk(i_clk), .i_rst(i_rst), .trap_valid(trap_valid), .trap_is_irq(trap_is_irq),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_valid(mret_valid), .trap_ready(trap_ready_0), .stall(stall_0),
        .csr_addr(csr_addr_0), .csr_we(csr_we_0), .csr_re(csr_re_0), .funct3(funct3_0),
        .o_data(o_data_0), .i_data(i_data_0), .pc_redirect(pc_redirect_0),
        .pc_target(pc_target_0), .dbg_state(dbg_state_0)
    );

    // Clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // CSR file read model (combinational read data)
    always_comb begin
        i_data = '0;
        if (csr_re && csr_addr == 12'h305) i_data = mtvec_v;
        if (csr_re && csr_addr == 12'h341) i_data = mepc_v;
    end
    always_comb begin
        i_data_0 = '0;
        if (csr_re_0 && csr_addr_0 == 12'h305) i_data_0 = mtvec_v;
        if (csr_re_0 && csr_addr_0 == 12'h341) i_data_0 = mepc_v;
    end

    function automatic logic [51:0] obs();
        return {stall, trap_ready, csr_we, csr_re, pc_redirect, funct3, csr_addr, o_data};
    endfunction

    function automatic logic [51:0] pk(input logic st, input logic rdy, input logic we,
                                       input logic re, input logic rd, input logic [2:0] f3,
                                       input logic [11:0] a, input logic [31:0] d);
        return {st, rdy, we, re, rd, f3, a, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp,
                       input logic [63:0] mask);
        total++;
        if ((act & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act & mask, exp & mask, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_trap(input int idx, input bit mret_too, input bit late_trap);
        vec_t v;
        v = vecs[idx];
        step();
        trap_valid  = 1'b1;
        trap_is_irq = v.irq;
        trap_cause  = v.cause;
        trap_pc     = v.pc;
        trap_tval   = v.tval;
        mret_valid  = mret_too;
        mtvec_v     = v.mtvec;
        @(negedge i_clk);
        chk($sformatf("v%0d idle", idx), 64'(obs()), 64'(pk(0, 1, 0, 0, 0, 0, 0, 0)), 64'(M_FULL));
        step();
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        @(negedge i_clk);
        chk($sformatf("v%0d mepc_wr", idx), 64'(obs()),
            64'(pk(1, 0, 1, 0, 0, 3'b001, 12'h341, v.exp_epc)), 64'(M_FULL));
        step();
        if (late_trap) begin
            trap_valid = 1'b1;
            trap_is_irq = ~v.irq;
            trap_cause = 5'd9;
            trap_pc = 32'h0000_BAD0;
            trap_tval = 32'h0BAD_0BAD;
        end
        @(negedge i_clk);
        chk($sformatf("v%0d mcause_wr", idx), 64'(obs()),
            64'(pk(1, 0, 1, 0, 0, 3'b001, 12'h342, v.exp_cause)), 64'(M_FULL));
        step();
        @(negedge i_clk);
        chk($sformatf("v%0d mtval_wr", idx), 64'(obs()),
            64'(pk(1, 0, 1, 0, 0, 3'b001, 12'h343, v.tval)), 64'(M_FULL));
        step();
        @(negedge i_clk);
        chk($sformatf("v%0d mtvec_rd", idx), 64'(obs()),
            64'(pk(1, 0, 0, 1, 0, 0, 12'h305, 0)), 64'(M_RD));
        step();
        trap_valid = 1'b0;
        @(negedge i_clk);
        chk($sformatf("v%0d redir", idx), 64'(obs()), 64'(pk(1, 0, 0, 0, 1, 0, 0, 0)), 64'(M_FULL));
        chk($sformatf("v%0d tgt_vec", idx), 64'(pc_target), 64'(v.exp_tgt_v), '1);
        chk($sformatf("v%0d tgt_dir", idx), 64'(pc_target_0), 64'(v.exp_tgt_d), '1);
        step();
        @(negedge i_clk);
        chk($sformatf("v%0d back_idle", idx), 64'(obs()), 64'(pk(0, 1, 0, 0, 0, 0, 0, 0)), 64'(M_FULL));
        chk($sformatf("v%0d tgt_hold", idx), 64'(pc_target), 64'(v.exp_tgt_v), '1);
        step();
        @(negedge i_clk);
        chk($sformatf("v%0d stay_idle", idx), 64'(obs()), 64'(pk(0, 1, 0, 0, 0, 0, 0, 0)), 64'(M_FULL));
    endtask

    task automatic release_reset(input string tag);
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        chk({tag, " ready_before_edge"}, 64'(obs()), 64'(0), 64'(M_FULL));
        @(negedge i_clk);
        chk({tag, " ready_after_edge"}, 64'(obs()), 64'(pk(0, 1, 0, 0, 0, 0, 0, 0)), 64'(M_FULL));
        chk({tag, " state_idle"}, 64'(dbg_state), 64'(0), '1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        i_rst = 1'b0;
        trap_valid = 1'b0;
        trap_is_irq = 1'b0;
        trap_cause = '0;
        trap_pc = '0;
        trap_tval = '0;
        mret_valid = 1'b0;
        mtvec_v = '0;
        mepc_v = '0;

        //         irq   cause  pc            tval          mtvec         epc           cause_word    tgt_vec       tgt_direct
        vecs[0] = '{1'b0, 5'd2,  32'h0000_1006, 32'hDEAD_BEEF, 32'h8000_0000, 32'h0000_1004, 32'h0000_0002, 32'h8000_0000, 32'h8000_0000};
        vecs[1] = '{1'b1, 5'd7,  32'h0000_3000, 32'h0000_0000, 32'h8000_0001, 32'h0000_3000, 32'h8000_0007, 32'h8000_001C, 32'h8000_0000};
        vecs[2] = '{1'b0, 5'd7,  32'h0000_4003, 32'h1234_5678, 32'h8000_0001, 32'h0000_4000, 32'h0000_0007, 32'h8000_0000, 32'h8000_0000};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h8000_001F, 32'h0000_0078, 32'hFFFF_FFFC};
        vecs[4] = '{1'b1, 5'd3,  32'h0000_0008, 32'hA5A5_A5A5, 32'h0000_0102, 32'h0000_0008, 32'h8000_0003, 32'h0000_0100, 32'h0000_0100};

        // Reset state
        @(negedge i_clk);
        chk("rst outputs", 64'(obs()), 64'(0), 64'(M_FULL));
        chk("rst target", 64'({pc_target, pc_target_0}), 64'(0), '1);
        @(negedge i_clk);
        chk("rst hold", 64'(obs()), 64'(0), 64'(M_FULL));
        release_reset("rst1");

        // Table of trap sequences
        for (int i = 0; i < 5; i++) run_trap(i, 1'b0, 1'b0);

        // Trap and mret together, with a second trap raised during mcause write
        run_trap(0, 1'b1, 1'b1);

        // mret sequence
        mepc_v = 32'h0000_2003;
        step();
        mret_valid = 1'b1;
        @(negedge i_clk);
        chk("mret idle", 64'(obs()), 64'(pk(0, 1, 0, 0, 0, 0, 0, 0)), 64'(M_FULL));
        step();
        mret_valid = 1'b0;
        @(negedge i_clk);
        chk("mret mepc_rd", 64'(obs()), 64'(pk(1, 0, 0, 1, 0, 0, 12'h341, 0)), 64'(M_RD));
        step();
        @(negedge i_clk);
        chk("mret redir", 64'(obs()), 64'(pk(1, 0, 0, 0, 1, 0, 0, 0)), 64'(M_FULL));
        chk("mret target", 64'(pc_target), 64'(32'h0000_2000), '1);
        step();
        @(negedge i_clk);
        chk("mret done", 64'(obs()), 64'(pk(0, 1, 0, 0, 0, 0, 0, 0)), 64'(M_FULL));
        chk("mret tgt_hold", 64'(pc_target), 64'(32'h0000_2000), '1);

        // Reset asserted during the mtval write aborts the sequence
        step();
        trap_valid = 1'b1;
        trap_is_irq = 1'b1;
        trap_cause = 5'd7;
        trap_pc = 32'h0000_5000;
        trap_tval = 32'h0000_0042;
        mtvec_v = 32'h8000_0001;
        step();
        trap_valid = 1'b0;
        step();
        step();
        @(negedge i_clk);
        chk("abort mtval_wr", 64'(obs()), 64'(pk(1, 0, 1, 0, 0, 3'b001, 12'h343, 32'h42)), 64'(M_FULL));
        #2;
        i_rst = 1'b0;
        #1;
        chk("abort outputs", 64'(obs()), 64'(0), 64'(M_FULL));
        chk("abort target", 64'({pc_target, pc_target_0}), 64'(0), '1);
        @(negedge i_clk);
        chk("abort hold", 64'(obs()), 64'(0), 64'(M_FULL));
        release_reset("rst2");
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk($sformatf("abort no_redir%0d", k), 64'(obs()),
                64'(pk(0, 1, 0, 0, 0, 0, 0, 0)), 64'(M_FULL));
        end

        // Fresh trap after the abort still works end to end
        run_trap(1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
